// File: rtl/inversor_seq_if.sv
// inversor_seq_if: run control and inverter probe bundle for inversor_seq.
// INVERSOR_SEQ_FIRST_FAIL_EN adds the first-failure capture signals.
interface inversor_seq_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] inv_y;
    logic [WIDTH-1:0] inv_a;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH:0]   err_cnt;
`ifdef INVERSOR_SEQ_FIRST_FAIL_EN
    logic [WIDTH-1:0] first_fail_a;
    logic             first_fail_vld;
    modport slave  (input start, inv_y, output inv_a, busy, done, pass, err_cnt, first_fail_a, first_fail_vld);
    modport master (output start, inv_y, input inv_a, busy, done, pass, err_cnt, first_fail_a, first_fail_vld);
`else
    modport slave  (input start, inv_y, output inv_a, busy, done, pass, err_cnt);
    modport master (output start, inv_y, input inv_a, busy, done, pass, err_cnt);
`endif
endinterface

// File: rtl/inversor_seq.sv
// inversor_seq: sweeps every code through the inverter and counts complement mismatches.
// INVERSOR_SEQ_FIRST_FAIL_EN adds capture of the first failing code.
module inversor_seq #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 2
) (
    input logic          clk,
    input logic          rst_n,
    inversor_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
    state_t           state_q;
    logic [7:0]       hold_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   err_q;
    logic [WIDTH:0]   err_d;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             mis;
`ifdef INVERSOR_SEQ_FIRST_FAIL_EN
    logic [WIDTH-1:0] ff_a_q;
    logic             ff_vld_q;
`endif
    assign mis   = bus.inv_y != ~a_q;
    assign err_d = err_q + {{WIDTH{1'b0}}, mis};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            a_q      <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef INVERSOR_SEQ_FIRST_FAIL_EN
            ff_a_q   <= '0;
            ff_vld_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    err_q    <= '0;
                    pass_q   <= 1'b0;
                    a_q      <= '0;
                    hold_q   <= '0;
                    busy_q   <= 1'b1;
                    state_q  <= APPLY;
`ifdef INVERSOR_SEQ_FIRST_FAIL_EN
                    ff_a_q   <= '0;
                    ff_vld_q <= 1'b0;
`endif
                end
                APPLY: begin
                    hold_q <= hold_q + 8'd1;
                    if (hold_q == HOLD_M1) state_q <= SAMPLE;
                end
                SAMPLE: begin
                    err_q <= err_d;
`ifdef INVERSOR_SEQ_FIRST_FAIL_EN
                    if (mis && !ff_vld_q) begin
                        ff_a_q   <= a_q;
                        ff_vld_q <= 1'b1;
                    end
`endif
                    // done/pass land on the same edge busy drops, using this sample's count
                    if (&a_q) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= err_d == '0;
                    end else begin
                        a_q     <= a_q + 1'b1;
                        hold_q  <= '0;
                        state_q <= APPLY;
                    end
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.inv_a   = a_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
`ifdef INVERSOR_SEQ_FIRST_FAIL_EN
    assign bus.first_fail_a   = ff_a_q;
    assign bus.first_fail_vld = ff_vld_q;
`endif
endmodule

// File: tb/tb_inversor_seq.sv
// tb_inversor_seq: randomized fault-mask runs checked cycle by cycle against a sweep model.
module tb_inversor_seq;
    logic       clk;
    logic       rst_n;
    logic [3:0] fmask;
    int         n_chk;
    int         n_err;

    inversor_seq_if #(.WIDTH(4)) sif  ();
    inversor_seq_if #(.WIDTH(4)) sif1 ();

    inversor_seq #(.WIDTH(4), .HOLD(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(sif));
    inversor_seq #(.WIDTH(4), .HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(sif1));

    // faulty inverter: bits set in fmask are stuck at 0
    assign sif.inv_y  = ~sif.inv_a & ~fmask;
    assign sif1.inv_y = ~sif1.inv_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input int k, input logic [3:0] m);
        return ((~k) & int'(m) & 15) != 0;
    endfunction

    function automatic int n_bad(input int upto, input logic [3:0] m);
        int n = 0;
        for (int k = 0; k < upto; k++) if (is_bad(k, m)) n++;
        return n;
    endfunction

    function automatic int first_bad(input int upto, input logic [3:0] m);
        for (int k = 0; k < upto; k++) if (is_bad(k, m)) return k;
        return 0;
    endfunction

    // one HOLD=2 run; c counts edges after E0, sampled 1ns after each edge
    task automatic run(input logic [3:0] m, input int restart_at);
        int done_seen;
        fmask = m;
        done_seen = 0;
        sif.start = 1'b1;
        tick;
        for (int c = 0; c <= 49; c++) begin
            int ns = c / 3;
            sif.start = (c == restart_at);
            if (sif.done) done_seen++;
            chk("busy", int'(sif.busy), int'(c < 48));
            chk("done", int'(sif.done), int'(c == 48));
            chk("inv_a", int'(sif.inv_a), c < 48 ? ns : 15);
            chk("err_cnt", int'(sif.err_cnt), n_bad(ns, m));
            chk("pass", int'(sif.pass), int'(c >= 48 && n_bad(16, m) == 0));
`ifdef INVERSOR_SEQ_FIRST_FAIL_EN
            chk("ff_vld", int'(sif.first_fail_vld), int'(n_bad(ns, m) != 0));
            chk("ff_a", int'(sif.first_fail_a), first_bad(ns, m));
`endif
            tick;
        end
        sif.start = 1'b0;
        chk("done_pulses", done_seen, 1);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        fmask = 4'd0;
        sif.start = 1'b0;
        sif1.start = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_inv_a", int'(sif.inv_a), 0);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_done", int'(sif.done), 0);
        chk("rst_pass", int'(sif.pass), 0);
        chk("rst_err", int'(sif.err_cnt), 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        run(4'd0, -1);
        run(4'd1, -1);
        chk("stuck0_err", int'(sif.err_cnt), 8);
        run(4'd0, 10);
        for (int r = 0; r < 3; r++) run(4'($urandom_range(1, 15)), -1);

        // start held high: second run begins 2 edges after done
        fmask = 4'd0;
        sif.start = 1'b1;
        tick;
        for (int c = 0; c <= 50; c++) begin
            if (c == 48) chk("held_done", int'(sif.done), 1);
            if (c == 49) chk("held_gap", int'(sif.busy | sif.done), 0);
            if (c == 50) begin
                chk("held_busy2", int'(sif.busy), 1);
                chk("held_a2", int'(sif.inv_a), 0);
                chk("held_err2", int'(sif.err_cnt), 0);
            end
            tick;
        end
        sif.start = 1'b0;

        // async reset mid-run at code 7, with a count already accumulated
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        tick;
        fmask = 4'd1;
        sif.start = 1'b1;
        tick;
        sif.start = 1'b0;
        for (int c = 0; c < 21; c++) tick;
        chk("mid_inv_a", int'(sif.inv_a), 7);
        chk("mid_err", int'(sif.err_cnt), n_bad(7, 4'd1));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_inv_a", int'(sif.inv_a), 0);
        chk("ar_busy", int'(sif.busy), 0);
        chk("ar_done", int'(sif.done), 0);
        chk("ar_pass", int'(sif.pass), 0);
        chk("ar_err", int'(sif.err_cnt), 0);
        #1 rst_n = 1'b1;
        tick;
        tick;
        chk("idle_busy", int'(sif.busy), 0);
        sif.start = 1'b1;
        tick;
        sif.start = 1'b0;
        chk("restart_a", int'(sif.inv_a), 0);
        chk("restart_busy", int'(sif.busy), 1);

        // HOLD=1 instance: done 32 edges after E0
        begin
            int cnt = 0;
            sif1.start = 1'b1;
            tick;
            sif1.start = 1'b0;
            while (!sif1.done && cnt < 200) begin
                tick;
                cnt++;
            end
            chk("h1_done_lat", cnt, 32);
            chk("h1_pass", int'(sif1.pass), 1);
            chk("h1_err", int'(sif1.err_cnt), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
